// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and helpers for the PWM generator
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } pwm_state_e;

  function automatic int duty_w(input int width);
    return width + 1;
  endfunction

  // Clamp a requested duty to the full period length 2^width.
  function automatic logic [31:0] sat_duty(input logic [31:0] duty, input int width);
    logic [31:0] full;
    full = 32'd1 << width;
    return (duty > full) ? full : duty;
  endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// rtl/pwm_gen_if.sv - duty value valid/ready handshake bundle
interface pwm_gen_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = 3
) ();

  localparam int DUTY_W = duty_w(WIDTH);

  logic [DUTY_W-1:0] duty_in;
  logic              duty_valid;
  logic              duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);

endinterface

// File: rtl/pwm_gen_duty_buffer.sv
// rtl/pwm_gen_duty_buffer.sv - shadow/active duty registers with valid/ready intake
module duty_buffer
  import pwm_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic           clk,
  input  logic           res,
  pwm_gen_if.slave       duty_bus,
  input  logic           commit,
  output logic [WIDTH:0] duty_active_next
);

  localparam int DUTY_W = duty_w(WIDTH);

  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              pending_q, pending_d;

  // A commit only happens with pending set, which keeps the slot closed to new
  // transfers on that edge; a transfer at a period start therefore waits a period.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (commit && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (duty_bus.duty_valid && !pending_q) begin
      shadow_d  = DUTY_W'(sat_duty(32'(duty_bus.duty_in), WIDTH));
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign duty_bus.duty_ready = !pending_q;
  assign duty_active_next    = active_d;

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - counter-driven PWM with period-aligned duty updates and sync check
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] cnt,
  input  logic             en,
  pwm_gen_if.slave         duty_bus,
  output logic             pwm,
  output logic             period_start,
  output logic             sync_err,
  input  logic             err_clr
);

  pwm_state_e       state_q, state_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             sync_err_q, sync_err_d;
  logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
  logic             discont;
  logic [WIDTH:0]   duty_active_next;

  duty_buffer #(.WIDTH(WIDTH)) u_duty_buffer (
    .clk              (clk),
    .res              (res),
    .duty_bus         (duty_bus),
    .commit           (period_start_d),
    .duty_active_next (duty_active_next)
  );

  assign discont = (cnt != WIDTH'(prev_cnt_q + 1'b1));

  always_comb begin
    state_d    = state_q;
    prev_cnt_d = cnt;
    sync_err_d = err_clr ? 1'b0 : sync_err_q;
    case (state_q)
      IDLE: if (en) state_d = ARM;
      ARM: begin
        if (!en)              state_d = IDLE;
        else if (cnt == '0)   state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (discont) begin
          // A jump back to zero still only re-arms; RUN waits for the next clean zero.
          state_d    = ARM;
          sync_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    period_start_d = (state_d == RUN) && (cnt == '0);
    pwm_d          = (state_d == RUN) && ({1'b0, cnt} < duty_active_next);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q        <= IDLE;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      sync_err_q     <= 1'b0;
      prev_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      sync_err_q     <= sync_err_d;
      prev_cnt_q     <= prev_cnt_d;
    end
  end

  assign pwm          = pwm_q;
  assign period_start = period_start_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen with a behavioural model
module tb_pwm_gen;

  localparam int W   = 3;
  localparam int PER = 8;

  logic         clk;
  logic         res;
  logic [W-1:0] cnt;
  logic         en;
  logic         err_clr;
  logic         pwm;
  logic         period_start;
  logic         sync_err;

  pwm_gen_if #(.WIDTH(W)) bus ();

  pwm_gen #(.WIDTH(W)) dut (
    .clk          (clk),
    .res          (res),
    .cnt          (cnt),
    .en           (en),
    .duty_bus     (bus),
    .pwm          (pwm),
    .period_start (period_start),
    .sync_err     (sync_err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;

  // Reference model: mode 0 = stopped, 1 = waiting for a clean zero, 2 = running.
  int m_mode, m_prev, m_active, m_shadow;
  bit m_pending, m_pwm, m_ps, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_active = 0; m_shadow = 0;
    m_pending = 0; m_pwm = 0; m_ps = 0; m_err = 0;
  endtask

  task automatic tick();
    bit xfer, disc, run_next;
    int c;
    c        = int'(cnt);
    xfer     = bus.duty_valid && !m_pending;
    disc     = (m_mode == 2) && en && (c != (m_prev + 1) % PER);
    run_next = en && !disc && ((m_mode == 1 && c == 0) || m_mode == 2);
    if (run_next && c == 0 && m_pending) begin
      m_active  = m_shadow;
      m_pending = 0;
    end
    if (xfer) begin
      m_shadow  = (int'(bus.duty_in) > PER) ? PER : int'(bus.duty_in);
      m_pending = 1;
    end
    m_pwm  = run_next && (c < m_active);
    m_ps   = run_next && (c == 0);
    m_err  = disc || (m_err && !err_clr);
    m_mode = !en ? 0 : (run_next ? 2 : 1);
    m_prev = c;
    @(posedge clk);
    #1;
    chk("pwm", 32'(pwm), 32'(m_pwm));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("duty_ready", 32'(bus.duty_ready), 32'(!m_pending));
    if (pwm) hi_cnt++;
    @(negedge clk);
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cnt = cnt + 1'b1;
    end
  endtask

  task automatic load(input int d);
    bus.duty_valid = 1'b1;
    bus.duty_in    = (W+1)'(d);
    tick();
    bus.duty_valid = 1'b0;
    cnt = cnt + 1'b1;
  endtask

  initial begin
    res = 1'b0; en = 1'b0; err_clr = 1'b0; cnt = '0;
    bus.duty_valid = 1'b0; bus.duty_in = '0;
    model_reset();
    #12;
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_ps", 32'(period_start), 0);
    chk("rst_err", 32'(sync_err), 0);
    chk("rst_ready", 32'(bus.duty_ready), 1);
    @(negedge clk);
    res = 1'b1;

    // Basic duty 3: arm, then 3 high / 5 low per period.
    cnt = 3'd5;
    load(3);
    en = 1'b1;
    free(2);
    hi_cnt = 0; free(PER); chk("basic_hi_p1", 32'(hi_cnt), 3);
    hi_cnt = 0; free(PER); chk("basic_hi_p2", 32'(hi_cnt), 3);

    // Duty 0, then a coincident load of 8 that must wait one period.
    free(3); load(0); free(4);
    hi_cnt = 0; free(PER); chk("duty0_hi", 32'(hi_cnt), 0);
    hi_cnt = 0; load(8); free(PER-1); chk("coincident_hold", 32'(hi_cnt), 0);
    hi_cnt = 0; free(PER); chk("duty8_hi", 32'(hi_cnt), 8);
    load(12); free(PER-1);
    hi_cnt = 0; free(PER); chk("duty12_sat_hi", 32'(hi_cnt), 8);

    // Double buffering: load 6 at cnt=4 while 2 is active.
    free(1); load(2); free(PER-2);
    hi_cnt = 0; free(4);
    load(6);
    chk("dbuf_ready_low", 32'(bus.duty_ready), 0);
    free(3); chk("dbuf_cur_hi", 32'(hi_cnt), 2);
    hi_cnt = 0; free(PER); chk("dbuf_next_hi", 32'(hi_cnt), 6);

    // Counter reset mid-period: 0,1,2,3,0.
    free(4);
    cnt = 3'd0; tick();
    chk("disc_err", 32'(sync_err), 1);
    chk("disc_pwm", 32'(pwm), 0);
    cnt = 3'd1; free(PER-1);
    free(1);
    chk("resume_ps", 32'(period_start), 1);
    free(2);
    cnt = 3'd6; err_clr = 1'b1; tick();
    chk("err_set_beats_clr", 32'(sync_err), 1);
    cnt = 3'd7; tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(sync_err), 0);

    // Enable drop at cnt=5 with a pending value.
    cnt = 3'd0; free(3); load(3); free(1);
    en = 1'b0; tick(); cnt = cnt + 1'b1;
    chk("en_drop_pwm", 32'(pwm), 0);
    chk("en_drop_pending", 32'(bus.duty_ready), 0);
    free(3);
    en = 1'b1; free(2 * PER);

    // Asynchronous reset with an error flagged and a value pending.
    load(5);
    cnt = cnt + 3'd3; tick();
    #2 res = 1'b0;
    #1;
    chk("async_pwm", 32'(pwm), 0);
    chk("async_ps", 32'(period_start), 0);
    chk("async_err", 32'(sync_err), 0);
    chk("async_ready", 32'(bus.duty_ready), 1);
    model_reset();
    @(negedge clk);
    res = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      en             = ($urandom_range(0, 19) != 0);
      bus.duty_valid = ($urandom_range(0, 3) == 0);
      bus.duty_in    = (W+1)'($urandom_range(0, 15));
      err_clr        = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0) cnt = W'($urandom);
      else                            cnt = cnt + 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

Downstream consumer of the free-running `counter` value. Compares the incoming count against a double-buffered duty value to produce a registered PWM output, one period per counter wrap. Accepts new duty values over a valid/ready handshake and applies them only at period boundaries. Flags any break in count continuity, for example when the counter is reset mid-period.

## Interface
- `WIDTH`, default 3: count width; period = 2^WIDTH cycles.
- `clk`  in  1: clock, rising edge.
- `res`  in  1: asynchronous reset, active-low.
- `cnt`  in  WIDTH: counter value, sampled every rising edge.
- `en`  in  1: run enable, level.
- `duty_in`  in  WIDTH+1: requested high-time in cycles; range 0..2^WIDTH.
- `duty_valid`  in  1: duty_in valid.
- `duty_ready`  out  1: shadow slot free; equals !pending.
- `pwm`  out  1: PWM output, registered.
- `period_start`  out  1: one-cycle pulse, registered; a new period has begun in RUN.
- `sync_err`  out  1: sticky count-discontinuity flag.
- `err_clr`  in  1: clears `sync_err`.

## Operation
- Reset (res=0), asynchronous:
  - state=IDLE, pwm=0, period_start=0, sync_err=0.
  - duty_active=0, shadow=0, pending=0, so duty_ready=1.
  - prev_cnt=0.
- Handshake:
  - Transfer occurs when duty_valid && duty_ready at a rising edge.
  - On transfer, shadow <= min(duty_in, 2^WIDTH) and pending <= 1.
  - duty_in above 2^WIDTH saturates.
- Commit: at a period start, if pending=1 then duty_active <= shadow and pending <= 0.
- Period start: the edge at which sampled cnt==0 and the next state is RUN.
- FSM:
  - IDLE: pwm=0. Goes to ARM when en=1.
  - ARM: pwm=0; waits for a clean period. Goes to RUN when en=1 and cnt==0 (this is a period start). Goes to IDLE when en=0.
  - RUN: pwm <= (cnt < duty_active_next). Goes to IDLE when en=0; pwm=0 from the next edge. On a discontinuity, goes to ARM.
- Discontinuity: in RUN, cnt != (prev_cnt+1) mod 2^WIDTH.
  - Sets sync_err, forces pwm=0 and moves to ARM.
  - The pending duty value is kept.
- prev_cnt <= cnt on every edge.
- Comparison uses WIDTH+1 bits:
  - duty 0 gives a constant low output.
  - duty 2^WIDTH gives a constant high output in RUN.
- sync_err: set has priority over err_clr when both occur on the same edge.

## Timing
- pwm lags cnt by 1 cycle: the value reflects the cnt sampled at the previous edge.
- A new duty value takes effect on the first RUN period start after the transfer.
  - A transfer on the same edge as a period start is not applied; it commits at the following period start.
- duty_ready drops the cycle after a transfer. It rises the cycle after the commit.
- The period_start pulse is coincident with the first pwm bit of that period.
- en=0 in any state: pwm=0 and state=IDLE after one edge. pending and duty_active are retained.
- Counter reset mid-period (cnt jumps to 0 from a value other than 2^WIDTH-1):
  - sync_err=1 after one edge and state goes to ARM.
  - cnt==0 is already sampled on that edge, but it does not also start RUN. RUN resumes at the next cnt==0.
- res asserted mid-period: all outputs go to their reset values immediately, without waiting for clk.

## Structure
- Shared package `pwm_pkg`:
  - state enum (IDLE, ARM, RUN).
  - `DUTY_W = WIDTH+1` helper.
  - saturation function.
- One sub-module: `duty_buffer`, holding the shadow/pending/active registers and the handshake. The FSM and comparator stay in `pwm_gen`.
- The integration bench instantiates `counter` driving `cnt`, with the counter's reset tied to the bench.

## Test plan
- Basic duty:
  - Stimulus: reset, load duty=3, en=1, cnt free-running 0..7.
  - Required: ARM until cnt==0, then period_start pulses every 8 cycles; pwm high for 3 cycles and low for 5, lagging cnt by 1.
- Boundary duties:
  - duty=0 gives pwm constantly 0.
  - duty=8 gives pwm constantly 1 in RUN.
  - duty=12 saturates to 8.
- Double buffering:
  - Stimulus: mid-period (cnt=4) load duty=6 while active duty=2.
  - Required: current period keeps 2 high cycles; next period has 6; duty_ready is 0 from the transfer until the commit.
- Coincident load: a transfer on the edge where cnt==0 is applied one period later, not immediately.
- Counter reset mid-period:
  - Stimulus: cnt sequence 0,1,2,3,0.
  - Required: sync_err=1; pwm=0; ARM, then RUN at the next cnt==0; err_clr on the same edge as a new error leaves sync_err=1.
- Enable and reset mid-operation:
  - Stimulus: drop en at cnt=5.
  - Required: pwm=0 next cycle, IDLE, pending kept.
  - Stimulus: assert res asynchronously.
  - Required: all outputs at reset values before the next clk edge.
